// File: rtl/adder_mult_sequencer.sv
// adder_mult_sequencer
// Multi-cycle unsigned shift-and-add multiplier controller. It time-shares one
// external N-bit ripple adder (add_a/add_b out, add_out/add_cout back) and
// returns a 2N-bit product with a one-cycle done pulse after N iterations.
// Optional build macro MULT_ZERO_SKIP_EN: a start with a zero operand goes
// straight to DONE with a zero product and never drives the adder.
module adder_mult_sequencer #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic [N-1:0]   add_a,
   output logic [N-1:0]   add_b,
   input  logic [N-1:0]   add_out,
   input  logic           add_cout
);

   localparam int            CW   = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [N-1:0]  acc_hi, acc_lo, mcand;
   logic [CW-1:0] count;
   logic [N-1:0]  acc_hi_nx, acc_lo_nx;
   logic          zero_op;
   logic          last_iter;

`ifdef MULT_ZERO_SKIP_EN
   assign zero_op = (in_a == '0) || (in_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   // The adder's carry and sum shift right by one into the accumulator pair.
   assign acc_hi_nx = {add_cout, add_out[N-1:1]};
   assign acc_lo_nx = {add_out[0], acc_lo[N-1:1]};
   assign last_iter = (count == LAST);

   assign ready = (state == IDLE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of block order.
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic: start is only looked at in IDLE.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred for state_nx.
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = zero_op ? DONE : RUN;
         RUN:     if (last_iter) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Adder drive: only RUN uses the shared adder; it sees zeros otherwise.
   always_comb begin
      add_a = '0;
      add_b = '0;
      if (state == RUN) begin
         add_a = acc_hi;
         add_b = acc_lo[0] ? mcand : '0;
      end
   end

   // Datapath: operand capture on accepted start, one shift-add per RUN cycle,
   // product written only when the last iteration completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_hi  <= '0;
         acc_lo  <= '0;
         mcand   <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= in_a;
                  acc_lo <= in_b;
                  acc_hi <= '0;
                  count  <= '0;
                  if (zero_op) product <= '0;
               end
            end
            RUN: begin
               acc_hi <= acc_hi_nx;
               acc_lo <= acc_lo_nx;
               count  <= count + CW'(1);
               if (last_iter) product <= {acc_hi_nx, acc_lo_nx};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_mult_sequencer.sv
// tb_adder_mult_sequencer
// Self-checking bench: a behavioural adder stands in for the shared ripple
// adder, and every result is compared against plain integer multiplication
// with the latency the controller is expected to show.
module tb_adder_mult_sequencer;

   localparam int N    = 4;
   localparam int MAXW = 20;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   in_a = '0;
   logic [N-1:0]   in_b = '0;
   logic           ready, busy, done;
   logic [2*N-1:0] product;
   logic [N-1:0]   add_a, add_b, add_out;
   logic           add_cout;

   int vectors     = 0;
   int miscompares = 0;

   adder_mult_sequencer #(.N(N)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .in_a     (in_a),
      .in_b     (in_b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_out  (add_out),
      .add_cout (add_cout)
   );

   // Shared adder model.
   assign {add_cout, add_out} = {1'b0, add_a} + {1'b0, add_b};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit skips(input int a, input int b);
`ifdef MULT_ZERO_SKIP_EN
      return (a == 0) || (b == 0);
`else
      return 1'b0;
`endif
   endfunction

   // Called at the negedge following the accepting edge; counts further edges
   // until done shows up, checking busy on every cycle in between.
   task automatic wait_done(input bit exp_busy, output int lat);
      lat = 0;
      while (!done && lat < MAXW) begin
         if (exp_busy) check("busy_during_run", busy, 1);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input int a, input int b, input string tag);
      int             lat;
      int             w;
      int             exp_lat;
      logic [2*N-1:0] exp_p;
      bit             sk;
      sk      = skips(a, b);
      exp_p   = 8'(a * b);
      exp_lat = sk ? 0 : N;
      w = 0;
      while (!ready && w < MAXW) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_ready"}, ready, 1);
      start = 1'b1;
      in_a  = N'(a);
      in_b  = N'(b);
      @(negedge clk);
      start = 1'b0;
      in_a  = N'($urandom);
      in_b  = N'($urandom);
      wait_done(!sk, lat);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_product"}, product, exp_p);
      check({tag, "_adder_idle"}, {add_a, add_b}, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_ready_after"}, ready, 1);
      check({tag, "_product_held"}, product, exp_p);
   endtask

   initial begin
      int lat;
      // Reset state before any edge.
      #1;
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_adder", {add_a, add_b}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(3, 4, "mul_3x4");
      run_op(15, 15, "mul_15x15");
      run_op(1, 1, "mul_1x1");

      // start held high; operand changes during RUN are ignored.
      start = 1'b1;
      in_a  = 4'd2;
      in_b  = 4'd5;
      @(negedge clk);
      in_a = 4'd7;
      in_b = 4'd7;
      wait_done(1'b1, lat);
      check("held_first_latency", lat, N);
      check("held_first_product", product, 8'h0A);
      @(negedge clk);
      check("held_idle_ready", ready, 1);
      check("held_idle_done", done, 0);
      @(negedge clk);
      check("held_second_busy", busy, 1);
      start = 1'b0;
      wait_done(1'b1, lat);
      check("held_second_latency", lat, N);
      check("held_second_product", product, 8'h31);
      @(negedge clk);

      // Reset pulsed mid-RUN of 9*9 (count=2).
      start = 1'b1;
      in_a  = 4'd9;
      in_b  = 4'd9;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      check("abort_ready", ready, 1);
      check("abort_busy", busy, 0);
      check("abort_product", product, 0);
      check("abort_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      run_op(9, 9, "mul_9x9_after_abort");

      run_op(0, 13, "mul_0x13");
      run_op(11, 0, "mul_11x0");

      for (int i = 0; i < 30; i++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
